tawas_rcn_lsu: RTL
==================

# tawas_rcn_lsu

Parametrised load/store unit between the Tawas pipeline and an RCN master buffer. Forwards requests tagged with the issuing thread number, tracks outstanding reads and writes per thread, and stalls a thread until its read retires or while its write count is at the limit. Retires load data to the register file with the correct thread and destination register, aligned and sign- or zero-extended. Supersedes the fixed 32-thread interface with configurable thread count, write limit, per-read destination tracking and signed loads.

## Interface
- THREADS, 32, hardware thread count; power of two, 2..32; TW = log2(THREADS) is derived
- WR_MAX, 6, pending writes per thread that cause a stall; 1..15
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_thread  in  TW  issuing thread
- req_cs  in  1  request valid this cycle
- req_wr  in  1  1 = store, 0 = load
- req_xch  in  1  exchange: store that returns old data; valid only with req_wr=1
- req_signed  in  1  sign-extend load result
- req_addr  in  24  byte address
- req_mask  in  4  byte lanes
- req_wbreg  in  3  load destination register
- req_wdata  in  32  store data
- thread_stall  out  THREADS  per-thread stall, registered
- load_en  out  1  load retire strobe
- load_thread  out  TW  retiring thread
- load_reg  out  3  destination register
- load_data  out  32  aligned, extended data
- err  out  1  one-cycle protocol-error pulse
- m_cs, m_wr, m_xch  out  1 each  to master buffer
- m_seq  out  5  thread tag, zero-extended from TW
- m_addr  out  24;  m_mask  out  4;  m_wdata  out  32
- m_rdone  in  1  read or exchange completion
- m_wdone  in  1  write completion
- m_rsp_seq  in  5  completion tag
- m_rsp_mask  in  4  completion lanes
- m_rsp_data  in  32  completion data

## Operation
- Accepted request: req_cs=1 and req_thread not stalled. m_* is a combinational pass-through of the accepted request; m_seq = req_thread.
- A request from a stalled thread is not forwarded: m_cs=0, err pulses.
- Load or exchange: set rd_pend[t]; capture wbreg, mask and signed into per-thread slots.
- Plain store: wr_cnt[t] (4 bits) +1.
- m_wdone: wr_cnt[seq] −1. m_rdone: clear rd_pend[seq].
- Store accept and m_wdone on the same thread in the same cycle: count unchanged.
- m_wdone with count 0, m_rdone with rd_pend clear, or rsp_seq ≥ THREADS: ignored, err pulses.
- Both m_rdone and m_wdone asserted in the same cycle are legal and are both processed.
- thread_stall[t] <= rd_pend_next[t] | (wr_cnt_next[t] >= WR_MAX).
- Load data uses the captured mask:
  - 1111: whole word
  - 1100: bits [31:16]
  - 0011: bits [15:0]
  - single bit n: byte n
  - any other mask: whole word
- Halfword and byte results are sign-extended if signed, otherwise zero-extended.
- load_reg comes from the slot of rsp_seq, read before any same-cycle overwrite.

## Timing
- Reset: all outputs 0, all counters, rd_pend and slots cleared. Asserting rst mid-transaction discards all tracking; late completions then raise err.
- Request to m_cs: 0 cycles (combinational).
- Accepted load to thread_stall[t]=1: the next cycle.
- m_rdone to load_en: 1 cycle; load_en is a single-cycle pulse carrying load_thread, load_reg and load_data. thread_stall[t] falls on the same edge.
- Store that reaches WR_MAX: thread_stall set the next cycle. The m_wdone that drops the count below WR_MAX clears thread_stall the next cycle.
- err is registered: one cycle after the offending event.

## Test plan
- THREADS=8: thread 3 loads from 0x000010 with mask 0100 and signed=1; respond rdone with seq=3 and data 0x00800000 -> load_en 1 cycle later, load_thread=3, load_reg=wbreg, load_data=0xFFFFFF80; thread_stall[3] high from request+1 until the load_en cycle.
- WR_MAX=6: thread 5 issues 6 stores -> thread_stall[5] rises after the 6th; one m_wdone for seq 5 -> stall clears the next cycle.
- Same cycle: store from thread 2 and m_wdone for seq 2 -> wr_cnt[2] unchanged, no err.
- m_wdone for seq 7 with wr_cnt[7]=0 -> err pulses once, counters unchanged; req_cs from thread 3 while stalled -> m_cs=0 and err pulses.
- Exchange from thread 1 with wbreg 6 and mask 0011, response data 0x1234ABCD, unsigned -> load_data=0x0000ABCD, load_reg=6, wr_cnt[1] unchanged.
- Loads pending on threads 0 and 4, rst asserted -> all thread_stall bits 0 immediately; a later rdone for seq 0 -> err, load_en stays 0.

Source files
------------

// File: rtl/tawas_rcn_lsu.sv
// Load/store unit between the Tawas pipeline and an RCN master buffer: tags requests with the thread,
// tracks per-thread pending reads/writes and stalls, and retires load data one cycle after m_rdone.
module tawas_rcn_lsu #(
    parameter int THREADS = 32,
    parameter int WR_MAX  = 6,
    localparam int TW     = $clog2(THREADS)
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [TW-1:0]       req_thread,
    input  logic                req_cs,
    input  logic                req_wr,
    input  logic                req_xch,
    input  logic                req_signed,
    input  logic [23:0]         req_addr,
    input  logic [3:0]          req_mask,
    input  logic [2:0]          req_wbreg,
    input  logic [31:0]         req_wdata,

    output logic [THREADS-1:0]  thread_stall,
    output logic                load_en,
    output logic [TW-1:0]       load_thread,
    output logic [2:0]          load_reg,
    output logic [31:0]         load_data,
    output logic                err,

    output logic                m_cs,
    output logic                m_wr,
    output logic                m_xch,
    output logic [4:0]          m_seq,
    output logic [23:0]         m_addr,
    output logic [3:0]          m_mask,
    output logic [31:0]         m_wdata,

    input  logic                m_rdone,
    input  logic                m_wdone,
    input  logic [4:0]          m_rsp_seq,
    input  logic [3:0]          m_rsp_mask,
    input  logic [31:0]         m_rsp_data
);

    logic [THREADS-1:0]        rd_pend_q, rd_pend_d;
    logic [THREADS-1:0]        stall_q, stall_d;
    logic [THREADS-1:0][3:0]   wr_cnt_q, wr_cnt_d;
    logic [THREADS-1:0][2:0]   slot_reg_q, slot_reg_d;
    logic [THREADS-1:0][3:0]   slot_mask_q, slot_mask_d;
    logic [THREADS-1:0]        slot_sgn_q, slot_sgn_d;

    logic                      err_q;
    logic                      load_en_q;
    logic [TW-1:0]             load_thread_q;
    logic [2:0]                load_reg_q;
    logic [31:0]               load_data_q;

    logic                      accept;
    logic                      acc_rd;
    logic                      acc_st;
    logic                      seq_ok;
    logic [TW-1:0]             rsp_idx;
    logic                      rd_ok;
    logic                      wr_ok;
    logic                      err_d;
    logic [3:0]                rmask;
    logic                      rsgn;
    logic [31:0]               ext_data;

    // Lane information is taken from the slot captured at request time.
    logic                      unused_rsp_mask;
    assign unused_rsp_mask = ^m_rsp_mask;

    assign accept  = req_cs & ~stall_q[req_thread];
    assign acc_rd  = accept & (~req_wr | req_xch);
    assign acc_st  = accept & req_wr & ~req_xch;

    assign seq_ok  = ({1'b0, m_rsp_seq} < 6'(THREADS));
    assign rsp_idx = m_rsp_seq[TW-1:0];
    assign rd_ok   = m_rdone & seq_ok & rd_pend_q[rsp_idx];
    assign wr_ok   = m_wdone & seq_ok & (wr_cnt_q[rsp_idx] != 4'd0);
    assign err_d   = (req_cs & ~accept) | (m_rdone & ~rd_ok) | (m_wdone & ~wr_ok);

    assign m_cs    = accept;
    assign m_wr    = accept & req_wr;
    assign m_xch   = accept & req_wr & req_xch;
    assign m_seq   = accept ? 5'(req_thread) : 5'd0;
    assign m_addr  = accept ? req_addr  : 24'd0;
    assign m_mask  = accept ? req_mask  : 4'd0;
    assign m_wdata = accept ? req_wdata : 32'd0;

    assign rmask = slot_mask_q[rsp_idx];
    assign rsgn  = slot_sgn_q[rsp_idx];

    always_comb begin
        ext_data = m_rsp_data;
        case (rmask)
            4'b1111: ext_data = m_rsp_data;
            4'b1100: ext_data = {{16{rsgn & m_rsp_data[31]}}, m_rsp_data[31:16]};
            4'b0011: ext_data = {{16{rsgn & m_rsp_data[15]}}, m_rsp_data[15:0]};
            4'b1000: ext_data = {{24{rsgn & m_rsp_data[31]}}, m_rsp_data[31:24]};
            4'b0100: ext_data = {{24{rsgn & m_rsp_data[23]}}, m_rsp_data[23:16]};
            4'b0010: ext_data = {{24{rsgn & m_rsp_data[15]}}, m_rsp_data[15:8]};
            4'b0001: ext_data = {{24{rsgn & m_rsp_data[7]}},  m_rsp_data[7:0]};
            default: ext_data = m_rsp_data;
        endcase
    end

    always_comb begin
        rd_pend_d   = rd_pend_q;
        slot_reg_d  = slot_reg_q;
        slot_mask_d = slot_mask_q;
        slot_sgn_d  = slot_sgn_q;
        wr_cnt_d    = wr_cnt_q;
        stall_d     = stall_q;

        if (rd_ok) begin
            rd_pend_d[rsp_idx] = 1'b0;
        end
        if (acc_rd) begin
            rd_pend_d[req_thread]   = 1'b1;
            slot_reg_d[req_thread]  = req_wbreg;
            slot_mask_d[req_thread] = req_mask;
            slot_sgn_d[req_thread]  = req_signed;
        end

        // A store accept and a write completion on one thread cancel out.
        for (int t = 0; t < THREADS; t++) begin
            wr_cnt_d[t] = wr_cnt_q[t]
                        + 4'(acc_st && (req_thread == TW'(t)))
                        - 4'(wr_ok && (rsp_idx == TW'(t)));
            stall_d[t]  = rd_pend_d[t] | (wr_cnt_d[t] >= 4'(WR_MAX));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_q     <= '0;
            stall_q       <= '0;
            wr_cnt_q      <= '0;
            slot_reg_q    <= '0;
            slot_mask_q   <= '0;
            slot_sgn_q    <= '0;
            err_q         <= 1'b0;
            load_en_q     <= 1'b0;
            load_thread_q <= '0;
            load_reg_q    <= 3'd0;
            load_data_q   <= 32'd0;
        end else begin
            rd_pend_q   <= rd_pend_d;
            stall_q     <= stall_d;
            wr_cnt_q    <= wr_cnt_d;
            slot_reg_q  <= slot_reg_d;
            slot_mask_q <= slot_mask_d;
            slot_sgn_q  <= slot_sgn_d;
            err_q       <= err_d;
            load_en_q   <= rd_ok;
            if (rd_ok) begin
                load_thread_q <= rsp_idx;
                load_reg_q    <= slot_reg_q[rsp_idx];
                load_data_q   <= ext_data;
            end
        end
    end

    assign thread_stall = stall_q;
    assign err          = err_q;
    assign load_en      = load_en_q;
    assign load_thread  = load_thread_q;
    assign load_reg     = load_reg_q;
    assign load_data    = load_data_q;

endmodule
